// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost flags,
// registered overflow/underflow pulses and selectable first-word-fall-through read.
module fifo_sync_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned FWFT      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;

  if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH < DEPTH)) begin : g_bad_params
    $error("fifo_sync_param: need 0 < AE_THRESH < AF_THRESH < DEPTH");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_count_nxt;
  logic              r_full;
  logic              r_empty;
  logic              r_af;
  logic              r_ae;
  logic              r_ovf;
  logic              r_udf;
  logic              w_wr_acc;
  logic              w_rd_acc;

  assign w_wr_acc = wr_en && !r_full;
  assign w_rd_acc = rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)      w_count_nxt = r_count + PTR_W'(1);
    else if (!w_wr_acc && w_rd_acc) w_count_nxt = r_count - PTR_W'(1);
  end

  // Flags are registered from the next count so they stay glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == PTR_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= PTR_W'(AF_THRESH));
      r_ae    <= (w_count_nxt <= PTR_W'(AE_THRESH));
      r_ovf   <= wr_en && r_full;
      r_udf   <= rd_en && r_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  if (FWFT == 0) begin : g_std
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
      end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
  end else begin : g_fwft
    // Head entry is shown directly; masked while empty so stale data never leaks.
    assign rd_data  = r_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign rd_valid = !r_empty;
  end

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: standard-read instance plus an FWFT instance.
module tb_fifo_sync_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  logic          f_wr_en, f_rd_en;
  logic [DW-1:0] f_wr_data;
  logic [DW-1:0] f_rd_data;
  logic          f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [AW:0]   f_count;

  logic [DW-1:0] m_q[$];
  int            n_chk  = 0;
  int            n_pass = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_param #(.DATA_W(DW), .ADDR_W(AW), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_fw (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk_flags(input logic exp_ovf, input logic exp_udf);
    int c;
    c = m_q.size();
    chk("count", 32'(count), 32'(c));
    chk("full", 32'(full), 32'(c == DEPTH));
    chk("empty", 32'(empty), 32'(c == 0));
    chk("almost_full", 32'(almost_full), 32'(c >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(c <= 2));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_udf));
  endtask

  // One clock of stimulus on the standard instance; model decides acceptance pre-edge.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
    logic          wacc, racc;
    logic [DW-1:0] exp_d;
    exp_d   = '0;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    wacc    = we && (m_q.size() < DEPTH);
    racc    = re && (m_q.size() > 0);
    if (racc) exp_d = m_q.pop_front();
    if (wacc) m_q.push_back(wd);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_flags(we && !wacc, re && !racc);
    chk("rd_valid", 32'(rd_valid), 32'(racc));
    if (racc) chk("rd_data", 32'(rd_data), 32'(exp_d));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Load some state, then hit reset mid-cycle and check without any edge.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    m_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1 chk_reset_outputs();

    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // Fill, overflow, simultaneous at full, drain, underflow.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h10, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Simultaneous at empty keeps the written word.
    step(1'b1, 8'h5A, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Steady interleave at occupancy 5 drives both pointers through their wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

    // Reset at count 9: old data must never return.
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    @(negedge clk);
    #3 rst = 1'b1;
    #1 chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    m_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // FWFT instance: head visible one cycle after the write, no rd_en needed.
    @(negedge clk);
    chk("fw_empty0", 32'(f_empty), 32'd1);
    chk("fw_valid0", 32'(f_rd_valid), 32'd0);
    f_wr_en = 1'b1; f_wr_data = 8'h3C;
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    chk("fw_rd_data", 32'(f_rd_data), 32'h3C);
    chk("fw_valid", 32'(f_rd_valid), 32'd1);
    chk("fw_count", 32'(f_count), 32'd1);
    @(posedge clk); #1;
    chk("fw_hold", 32'(f_rd_data), 32'h3C);
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    chk("fw_valid_pop", 32'(f_rd_valid), 32'd0);
    chk("fw_empty_pop", 32'(f_empty), 32'd1);
    chk("fw_udf", 32'(f_udf), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO top level. Use it wherever producer and consumer share one clock domain, so pointer synchronisers and Gray coding are not needed. It adds several features the dual-clock FIFO lacks: configurable data width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, registered overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.

## Interface
Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W (default 16).
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.
- FWFT, 0, read mode:
  - 0 = standard registered read.
  - 1 = first-word-fall-through.
- Legal range: 0 < AE_THRESH < AF_THRESH < DEPTH. Elaboration fails outside this range.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request (pop).
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data holds valid data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

## Operation
Storage and pointers:
- Storage is a DEPTH x DATA_W register array and is not reset.
- wr_ptr and rd_ptr are ADDR_W+1 bits wide. The low ADDR_W bits address memory.
- Both pointers wrap naturally modulo 2**(ADDR_W+1).
- count is held in a register and kept equal to wr_ptr - rd_ptr.

Accept rules, evaluated on pre-edge state:
- A write is accepted iff wr_en && !full.
- A read is accepted iff rd_en && !empty.

Simultaneous requests:
- Neither at a boundary: both are accepted and count is unchanged.
- full with wr_en && rd_en: the read is accepted, the write is rejected, and overflow pulses. Count drops to DEPTH-1.
- empty with wr_en && rd_en: the write is accepted, the read is rejected, and underflow pulses. Count rises to 1.

Flags:
- full, empty, almost_full and almost_empty are decoded only from registered count. They are glitch-free and carry no input-to-output combinational path.

Errors:
- overflow is registered and is 1 for exactly the cycle after a rejected write.
- underflow is registered and is 1 for exactly the cycle after a rejected read.
- A rejected operation changes no pointer and no memory location.

FWFT=0:
- An accepted read loads mem[rd_ptr] into the rd_data register and sets rd_valid to 1 for one cycle.
- Otherwise rd_valid is 0 and rd_data holds its last value.

FWFT=1:
- rd_data = mem[rd_ptr[ADDR_W-1:0]], an asynchronous read of the head entry.
- rd_valid = !empty.
- rd_en acknowledges the current word and advances to the next.

Reset:
- Asserting rst at any time immediately (asynchronously) forces:
  - pointers and count = 0;
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0;
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
- Memory contents are don't-care after reset. Data held before reset is never presented again.
- Writes and reads issued in the cycle rst deasserts are honoured at the next rising edge.

## Timing
- Write to empty deasserting: an accepted write at edge N makes count = 1 and empty = 0 after edge N.
- FWFT=1: the first word appears on rd_data with rd_valid = 1 in the same cycle empty deasserts, i.e. one cycle of latency.
- FWFT=0: rd_data and rd_valid update at the edge that accepts the read, so data is available one cycle after rd_en is sampled.
- Write then read of the same word: earliest completion is 2 edges in FWFT=0 (write edge, read edge).
- Flags and count change only at clock edges, except on asynchronous reset.
- Throughput: one write and one read per cycle sustained while 0 < count < DEPTH.

## Test plan
- Reset sequence: assert rst mid-cycle, then release → all outputs at the reset values above, count = 0, with no clock edge required. Then write 0xA5 and read → FWFT=0 returns rd_data = 0xA5 with rd_valid = 1 one cycle after rd_en.
- Fill and drain: 16 writes of 0x00..0x0F (default parameters) → almost_full asserts when count reaches 14, full at 16. A 17th write → overflow pulses one cycle and count stays 16. Then 16 reads → data 0x00..0x0F in order, almost_empty asserts when count falls to 2, empty at 0. A 17th read → underflow pulse.
- Simultaneous at boundaries:
  - full, wr_en = rd_en = 1 → count 15, overflow = 1, head word popped.
  - empty, wr_en = rd_en = 1 → count 1, underflow = 1, written word retained.
- Wrap-around: run 40 interleaved write/read cycles at occupancy 5 → no data loss or reorder, count constant at 5, and the pointers pass through their MSB wrap.
- FWFT=1 rebuild: write 0x3C to an empty FIFO → the next cycle shows rd_data = 0x3C and rd_valid = 1 with no rd_en. Pulse rd_en → rd_valid = 0 and empty = 1.
- Reset mid-operation: at count 9, assert rst → count 0 and empty = 1 immediately. After release, a new write followed by a read returns only the new word.
